// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the timed HD44780 LCD controller.
// Holds the phase FSM encoding, RW pin polarity and parameter legality checks.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        E_HI,
        HOLD,
        DONE
    } lcd_state_e;

    // LCD RW pin polarity; address[0] uses the same encoding.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DATA_W_8 = 8;
    localparam int DATA_W_4 = 4;

    function automatic bit data_w_legal(input int w);
        return (w == DATA_W_8) || (w == DATA_W_4);
    endfunction

    // A phase length must be at least one cycle and its terminal count must fit the timer.
    function automatic bit phase_fits(input int cyc, input int cnt_w);
        return (cyc >= 1) && ((cyc - 1) < (1 << cnt_w));
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Down-counter that times one FSM phase; reloaded on every phase entry.
// Loading N-1 makes expired rise on the N-th cycle spent in the phase.
module lcd_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/lcd_hd44780_timed_ctrl.sv
// Avalon-MM slave driving an HD44780 LCD with counted setup / E-pulse / hold phases.
// waitrequest stalls the master until the access (one byte or two nibbles) completes.
module lcd_hd44780_timed_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int T_AS_CYC  = 4,
    parameter int T_EPW_CYC = 12,
    parameter int T_H_CYC   = 30,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    output logic              waitrequest,
    output logic              LCD_E,
    output logic              LCD_RS,
    output logic              LCD_RW,
    inout  wire  [DATA_W-1:0] LCD_data
);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("lcd_hd44780_timed_ctrl: DATA_W must be 8 or 4");
    end
    if (!phase_fits(T_AS_CYC, CNT_W) || !phase_fits(T_EPW_CYC, CNT_W) ||
        !phase_fits(T_H_CYC, CNT_W)) begin : g_bad_timing
        $error("lcd_hd44780_timed_ctrl: phase lengths must be >= 1 and fit CNT_W");
    end

    localparam bit FOUR_BIT = (DATA_W == DATA_W_4);
    localparam logic [CNT_W-1:0] LOAD_AS  = CNT_W'(T_AS_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_EPW = CNT_W'(T_EPW_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_H   = CNT_W'(T_H_CYC - 1);

    lcd_state_e        state, state_next;
    logic              timer_load, expired;
    logic [CNT_W-1:0]  timer_value;
    logic              accept, legal, drive_next, sample;
    logic              drive_en, nib;
    logic [7:0]        wdata_q, rdbuf, rd_merge;
    logic [DATA_W-1:0] out_word;

    lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .value   (timer_value),
        .expired (expired)
    );

    // Byte <-> bus mapping: 4-bit mode sends the high nibble first on D7..D4.
    if (FOUR_BIT) begin : g_bus4
        assign out_word = nib ? wdata_q[3:0] : wdata_q[7:4];
        assign rd_merge = nib ? {rdbuf[7:4], LCD_data} : {LCD_data, rdbuf[3:0]};
    end else begin : g_bus8
        assign out_word = wdata_q;
        assign rd_merge = LCD_data;
    end

    // Write wins over a simultaneous read; direction mismatches finish with no LCD cycle.
    assign legal = write ? (address[0] == RW_WRITE) : (address[0] == RW_READ);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (read || write) begin
                    if (legal) begin
                        accept      = 1'b1;
                        state_next  = SETUP;
                        timer_load  = 1'b1;
                        timer_value = LOAD_AS;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SETUP: begin
                if (expired) begin
                    state_next  = E_HI;
                    timer_load  = 1'b1;
                    timer_value = LOAD_EPW;
                end
            end
            E_HI: begin
                if (expired) begin
                    state_next  = HOLD;
                    timer_load  = 1'b1;
                    timer_value = LOAD_H;
                end
            end
            HOLD: begin
                if (expired) begin
                    if (FOUR_BIT && !nib) begin
                        state_next  = SETUP;
                        timer_load  = 1'b1;
                        timer_value = LOAD_AS;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign drive_next = (state_next inside {SETUP, E_HI, HOLD}) &&
                        (accept ? write : (LCD_RW == RW_WRITE));
    assign sample     = (state == E_HI) && expired && (LCD_RW == RW_READ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            LCD_E    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_RW   <= RW_READ;
            drive_en <= 1'b0;
            wdata_q  <= '0;
            rdbuf    <= '0;
            nib      <= 1'b0;
        end else begin
            state    <= state_next;
            LCD_E    <= (state_next == E_HI);
            drive_en <= drive_next;
            if (accept) begin
                LCD_RS  <= address[1];
                LCD_RW  <= write ? RW_WRITE : RW_READ;
                wdata_q <= writedata;
                nib     <= 1'b0;
            end
            if (state == IDLE && state_next != IDLE) begin
                rdbuf <= '0;
            end else if (sample) begin
                rdbuf <= rd_merge;
            end
            if (state == HOLD && state_next == SETUP) begin
                nib <= 1'b1;
            end
        end
    end

    assign LCD_data    = drive_en ? out_word : {DATA_W{1'bz}};
    assign readdata    = (state == DONE) ? rdbuf : 8'h00;
    assign waitrequest = (read | write) & (state != DONE);

endmodule

// File: tb/tb_lcd_hd44780_timed_ctrl.sv
// Directed bench: one 8-bit and one 4-bit controller share the Avalon address/data inputs,
// with behavioural LCD models answering reads while E is high.
module tb_lcd_hd44780_timed_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] address = 2'b00;
    logic [7:0] writedata = 8'h00;
    logic       read8 = 1'b0, write8 = 1'b0, read4 = 1'b0, write4 = 1'b0;
    logic [7:0] readdata8, readdata4;
    logic       waitrequest8, waitrequest4;
    logic       lcd_e8, lcd_rs8, lcd_rw8, lcd_e4, lcd_rs4, lcd_rw4;
    wire  [7:0] lcd_data8;
    wire  [3:0] lcd_data4;

    logic [7:0] model_byte = 8'h80;
    logic [3:0] model_nib  = 4'hA;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lcd_hd44780_timed_ctrl #(.DATA_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read8), .write(write8),
        .writedata(writedata), .readdata(readdata8), .waitrequest(waitrequest8),
        .LCD_E(lcd_e8), .LCD_RS(lcd_rs8), .LCD_RW(lcd_rw8), .LCD_data(lcd_data8)
    );

    lcd_hd44780_timed_ctrl #(.DATA_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read4), .write(write4),
        .writedata(writedata), .readdata(readdata4), .waitrequest(waitrequest4),
        .LCD_E(lcd_e4), .LCD_RS(lcd_rs4), .LCD_RW(lcd_rw4), .LCD_data(lcd_data4)
    );

    // LCD models drive the bus only while E is high on a read cycle.
    assign lcd_data8 = (lcd_e8 && lcd_rw8) ? model_byte : 8'bz;
    assign lcd_data4 = (lcd_e4 && lcd_rw4) ? model_nib  : 4'bz;

    logic       sel4 = 1'b0;
    wire        m_wait  = sel4 ? waitrequest4 : waitrequest8;
    wire        m_e     = sel4 ? lcd_e4 : lcd_e8;
    wire        m_rs    = sel4 ? lcd_rs4 : lcd_rs8;
    wire        m_rw    = sel4 ? lcd_rw4 : lcd_rw8;
    wire  [7:0] m_rd    = sel4 ? readdata4 : readdata8;
    wire  [7:0] m_bus   = sel4 ? {4'h0, lcd_data4} : lcd_data8;
    wire  [7:0] m_model = sel4 ? {4'h0, model_nib} : model_byte;

    // Per-access observations filled in by run_access.
    int         wait_cyc, e_cyc, e_pulses, pat_cyc, first_pat, last_pat, first_rise, last_hi;
    int         rsrw_bad, cont_bad;
    logic [7:0] rd_got;
    logic [7:0] nib_cap [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // A released (z) bus never compares equal, so this only reports real drive.
    function automatic bit bus_eq(input logic [7:0] b, input logic [7:0] v);
        if (b == v) return 1'b1;
        return 1'b0;
    endfunction

    // Runs one Avalon access on the selected controller and records what the pins did.
    // pat is the value the FPGA would put on the bus; cycles showing it are counted.
    task automatic run_access(input string tag, input logic four, input logic wr, input logic rd,
                              input logic [1:0] addr, input logic [7:0] wd,
                              input logic [7:0] pat, input logic exp_rs);
        logic prev_e;
        bit   fin;
        wait_cyc = 0; e_cyc = 0; e_pulses = 0; pat_cyc = 0; rsrw_bad = 0; cont_bad = 0;
        first_pat = -1; last_pat = -1; first_rise = -1; last_hi = -1;
        rd_got = 8'h00; nib_cap[0] = 8'h00; nib_cap[1] = 8'h00;
        model_nib = 4'hA;
        prev_e = 1'b0;
        fin = 1'b0;
        @(negedge clk);
        sel4 = four; address = addr; writedata = wd;
        if (four) begin write4 = wr; read4 = rd; end
        else      begin write8 = wr; read8 = rd; end
        #1;
        for (int i = 0; i < 300 && !fin; i++) begin
            if (m_e) begin
                e_cyc++;
                last_hi = i;
                if (!prev_e) begin
                    if (e_pulses < 2) nib_cap[e_pulses] = m_bus;
                    if (first_rise < 0) first_rise = i;
                    e_pulses++;
                end
                if (m_rw == 1'b1 && !bus_eq(m_bus, m_model)) cont_bad++;
            end else if (prev_e) begin
                model_nib = 4'h5;
            end
            if (bus_eq(m_bus, pat)) begin
                pat_cyc++;
                if (first_pat < 0) first_pat = i;
                last_pat = i;
                if (m_rs !== exp_rs || m_rw !== 1'b0) rsrw_bad++;
            end
            prev_e = m_e;
            if (!m_wait) begin
                rd_got = m_rd;
                fin = 1'b1;
            end else begin
                wait_cyc++;
                @(negedge clk);
                #1;
            end
        end
        read8 = 1'b0; write8 = 1'b0; read4 = 1'b0; write4 = 1'b0;
        check({tag, "_completed"}, 32'(fin), 1);
    endtask

    initial begin
        bit seen;

        // Reset values while reset_n is held low.
        repeat (3) @(negedge clk);
        #1;
        check("rst_e", 32'(lcd_e8), 0);
        check("rst_rs", 32'(lcd_rs8), 0);
        check("rst_rw", 32'(lcd_rw8), 1);
        check("rst_rw4", 32'(lcd_rw4), 1);
        check("rst_readdata", 32'(readdata8), 0);
        check("rst_waitreq", 32'(waitrequest8), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8-bit data write 0x41: 1 + 4 + 12 + 30 = 47 wait cycles.
        run_access("w8", 1'b0, 1'b1, 1'b0, 2'b10, 8'h41, 8'h41, 1'b1);
        check("w8_latency", 32'(wait_cyc), 47);
        check("w8_e_width", 32'(e_cyc), 12);
        check("w8_e_pulses", 32'(e_pulses), 1);
        check("w8_setup_margin", 32'(first_rise - first_pat), 4);
        check("w8_hold_margin", 32'(last_pat - last_hi), 30);
        check("w8_drive_cycles", 32'(pat_cyc), 46);
        check("w8_rs_rw", 32'(rsrw_bad), 0);
        check("w8_e_data", 32'(nib_cap[0]), 32'h41);

        // 8-bit data read, LCD model returns 0x80; FPGA must never drive 0xFF.
        run_access("r8", 1'b0, 1'b0, 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0);
        check("r8_latency", 32'(wait_cyc), 47);
        check("r8_readdata", 32'(rd_got), 32'h80);
        check("r8_fpga_drive", 32'(pat_cyc), 0);
        check("r8_contention", 32'(cont_bad), 0);

        // 4-bit instruction write 0x38: nibbles 3 then 8, 1 + 2*46 = 93 wait cycles.
        run_access("w4", 1'b1, 1'b1, 1'b0, 2'b00, 8'h38, 8'h03, 1'b0);
        check("w4_latency", 32'(wait_cyc), 93);
        check("w4_e_pulses", 32'(e_pulses), 2);
        check("w4_nib0", 32'(nib_cap[0]), 32'h03);
        check("w4_nib1", 32'(nib_cap[1]), 32'h08);
        check("w4_nib0_cycles", 32'(pat_cyc), 46);
        check("w4_rs_rw", 32'(rsrw_bad), 0);

        // 4-bit read: model returns 0xA then 0x5.
        run_access("r4", 1'b1, 1'b0, 1'b1, 2'b01, 8'hFF, 8'h0F, 1'b0);
        check("r4_latency", 32'(wait_cyc), 93);
        check("r4_readdata", 32'(rd_got), 32'hA5);
        check("r4_e_pulses", 32'(e_pulses), 2);
        check("r4_fpga_drive", 32'(pat_cyc), 0);
        check("r4_contention", 32'(cont_bad), 0);

        // Direction mismatches complete after a single wait cycle with no E pulse.
        run_access("ill_w", 1'b0, 1'b1, 1'b0, 2'b01, 8'h55, 8'h55, 1'b0);
        check("ill_w_latency", 32'(wait_cyc), 1);
        check("ill_w_e_pulses", 32'(e_pulses), 0);
        check("ill_w_drive", 32'(pat_cyc), 0);
        run_access("ill_r", 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'hEE, 1'b0);
        check("ill_r_latency", 32'(wait_cyc), 1);
        check("ill_r_readdata", 32'(rd_got), 0);
        check("ill_r_e_pulses", 32'(e_pulses), 0);

        // Asynchronous reset while E is high on a write.
        @(negedge clk);
        sel4 = 1'b0; address = 2'b10; writedata = 8'hC3; write8 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (lcd_e8) seen = 1'b1;
        end
        check("rst_mid_reached_e", 32'(seen), 1);
        check("rst_mid_bus_before", 32'(bus_eq(lcd_data8, 8'hC3)), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_e_low", 32'(lcd_e8), 0);
        check("rst_mid_bus_released", 32'(bus_eq(lcd_data8, 8'hC3)), 0);
        check("rst_mid_rw", 32'(lcd_rw8), 1);
        write8 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // A fresh write after reset behaves normally.
        run_access("w8_post", 1'b0, 1'b1, 1'b0, 2'b10, 8'h41, 8'h41, 1'b1);
        check("w8_post_latency", 32'(wait_cyc), 47);
        check("w8_post_e_width", 32'(e_cyc), 12);
        check("w8_post_drive_cycles", 32'(pat_cyc), 46);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
